// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game controller and its display decoders:
// state encoding, LFSR geometry and default seed.
package genius_pkg;

  localparam int unsigned LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_APPEND   = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_GAP = 3'd3,
    ST_INPUT    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Fibonacci LFSR with synchronous reset to SEED.
module genius_lfsr
  import genius_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/genius_core.sv
// Genius (Simon) game controller: grows, replays and checks a random colour sequence.
// Optional input timeout enabled by defining GENIUS_TIMEOUT_EN.
module genius_core
  import genius_pkg::*;
#(
  parameter int unsigned       NUM_COLORS    = 4,
  parameter int unsigned       MAX_LEVEL     = 16,
  parameter int unsigned       SHOW_TICKS    = 4,
  parameter int unsigned       GAP_TICKS     = 2,
  parameter int unsigned       TIMEOUT_TICKS = 64,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = LFSR_SEED_DEFAULT,
  localparam int unsigned      CW            = $clog2(NUM_COLORS),
  localparam int unsigned      LW            = $clog2(MAX_LEVEL + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_COLORS-1:0] btn,
  output logic                  show_valid,
  output logic [CW-1:0]         show_color,
  output logic                  awaiting_input,
  output logic [LW-1:0]         level,
  output logic [LW-1:0]         step,
  output logic                  win,
  output logic                  lose
);

  localparam int unsigned MAXT = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TW   = $clog2(MAXT + 1);
  localparam int unsigned AW   = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

  state_e                  state_q, state_d;
  logic [LW-1:0]           level_q, level_d;
  logic [LW-1:0]           step_q, step_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic                    show_valid_q, show_valid_d;
  logic [CW-1:0]           show_color_q, show_color_d;
  logic                    awaiting_q, awaiting_d;
  logic                    win_q, win_d;
  logic                    lose_q, lose_d;

  logic [CW-1:0]           mem_q [MAX_LEVEL];
  logic                    mem_we;
  logic [LFSR_W-1:0]       lfsr;
  logic [CW-1:0]           draw_c;
  logic [CW-1:0]           cur_c;
  logic [NUM_COLORS-1:0]   exp_btn;
  logic                    last_step;
  logic                    unused_lfsr;

`ifdef GENIUS_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_TICKS + 1);
  logic [TOW-1:0] to_q, to_d;
`else
  localparam logic [31:0] UNUSED_TIMEOUT = 32'(TIMEOUT_TICKS);
`endif

  genius_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .lfsr_o (lfsr)
  );

  assign unused_lfsr = ^lfsr[LFSR_W-1:CW];

  // Fold out-of-range draws back into 0..NUM_COLORS-1
  always_comb begin
    draw_c = lfsr[CW-1:0];
    if ({1'b0, lfsr[CW-1:0]} >= (CW+1)'(NUM_COLORS))
      draw_c = CW'({1'b0, lfsr[CW-1:0]} - (CW+1)'(NUM_COLORS));
  end

  assign cur_c     = mem_q[step_q[AW-1:0]];
  assign exp_btn   = NUM_COLORS'(1) << cur_c;
  assign last_step = (step_q == LW'(level_q - LW'(1)));

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    step_d       = step_q;
    tick_d       = tick_q;
    mem_we       = 1'b0;
    show_valid_d = 1'b0;
    show_color_d = '0;
    awaiting_d   = 1'b0;
    win_d        = 1'b0;
    lose_d       = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
    to_d         = to_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          level_d = '0;
          step_d  = '0;
          state_d = ST_APPEND;
        end
      end
      ST_APPEND: begin
        mem_we  = 1'b1;
        level_d = level_q + LW'(1);
        step_d  = '0;
        tick_d  = '0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (tick_q == TW'(SHOW_TICKS - 1)) begin
          tick_d  = '0;
          state_d = ST_SHOW_GAP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_SHOW_GAP: begin
        if (tick_q == TW'(GAP_TICKS - 1)) begin
          tick_d = '0;
          if (last_step) begin
            step_d  = '0;
            state_d = ST_INPUT;
`ifdef GENIUS_TIMEOUT_EN
            to_d    = '0;
`endif
          end else begin
            step_d  = step_q + LW'(1);
            state_d = ST_SHOW_ON;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_INPUT: begin
        // A press always wins over an expiring timeout on the same cycle
        if (btn != '0) begin
          if (btn != exp_btn) begin
            state_d = ST_LOSE;
          end else begin
`ifdef GENIUS_TIMEOUT_EN
            to_d = '0;
`endif
            if (!last_step)                     step_d  = step_q + LW'(1);
            else if (level_q == LW'(MAX_LEVEL)) state_d = ST_WIN;
            else                                state_d = ST_APPEND;
          end
        end
`ifdef GENIUS_TIMEOUT_EN
        else if (to_q == TOW'(TIMEOUT_TICKS - 1)) state_d = ST_LOSE;
        else                                       to_d    = to_q + TOW'(1);
`endif
      end
      ST_WIN, ST_LOSE: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase

    // Registered outputs follow the next state; APPEND forwards the colour being written
    show_valid_d = (state_d == ST_SHOW_ON);
    if (show_valid_d) begin
      if (mem_we && (step_d == level_q)) show_color_d = draw_c;
      else                               show_color_d = mem_q[step_d[AW-1:0]];
    end
    awaiting_d = (state_d == ST_INPUT);
    win_d      = (state_d == ST_WIN);
    lose_d     = (state_d == ST_LOSE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      step_q       <= '0;
      tick_q       <= '0;
      show_valid_q <= 1'b0;
      show_color_q <= '0;
      awaiting_q   <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      step_q       <= step_d;
      tick_q       <= tick_d;
      show_valid_q <= show_valid_d;
      show_color_q <= show_color_d;
      awaiting_q   <= awaiting_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
`ifdef GENIUS_TIMEOUT_EN
      to_q         <= to_d;
`endif
    end
  end

  // Sequence memory is intentionally not reset
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[level_q[AW-1:0]] <= draw_c;
  end

  assign show_valid     = show_valid_q;
  assign show_color     = show_color_q;
  assign awaiting_input = awaiting_q;
  assign level          = level_q;
  assign step           = step_q;
  assign win            = win_q;
  assign lose           = lose_q;

endmodule

// File: doc/genius_core.md
# genius_core

Parametrised successor to the Genius (Simon) game controller. It generates a pseudo-random colour sequence, replays it one element at a time with programmable on/gap durations, then checks the player's button presses against it. The sequence grows by one element per cleared level up to a configurable maximum. The block sits between the debounced button front-end and the 7-segment/LED display logic, and exposes level, step and result pulses for those display decoders.

## Interface
Parameters:
- NUM_COLORS, 4: number of buttons/colours, 2..8; CW = $clog2(NUM_COLORS).
- MAX_LEVEL, 16: sequence length that wins the game, 1..64; LW = $clog2(MAX_LEVEL+1).
- SHOW_TICKS, 4: cycles each element is shown, ≥1.
- GAP_TICKS, 2: blank cycles after each shown element, ≥1.
- TIMEOUT_TICKS, 64: idle cycles allowed per input step; used only with GENIUS_TIMEOUT_EN.
- LFSR_SEED, 16'hACE1: LFSR reset value, non-zero.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a game; sampled only in IDLE.
- btn  in  NUM_COLORS  debounced, single-cycle press pulses, bit i = colour i.
- show_valid  out  1  high while an element is displayed.
- show_color  out  CW  colour being displayed; 0 when show_valid low.
- awaiting_input  out  1  high in INPUT.
- level  out  LW  current sequence length; held after a game ends until the next start.
- step  out  LW  index of the element being shown or expected.
- win  out  1  one-cycle pulse: MAX_LEVEL cleared.
- lose  out  1  one-cycle pulse: wrong, multiple or late press.

## Operation
- States: IDLE, APPEND, SHOW_ON, SHOW_GAP, INPUT, WIN, LOSE.
- 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle, including IDLE, so the sequence depends on when start arrives.
- Colour draw: c = lfsr[CW-1:0]. If c ≥ NUM_COLORS, use c − NUM_COLORS.
- IDLE: if start, then level←0, step←0, go to APPEND. Otherwise stay.
- APPEND (1 cycle): mem[level]←drawn colour, level←level+1, step←0, go to SHOW_ON.
- SHOW_ON: show_valid=1, show_color=mem[step] for SHOW_TICKS cycles, then go to SHOW_GAP.
- SHOW_GAP: GAP_TICKS cycles with outputs blank. Then:
  - if step == level−1: step←0, go to INPUT;
  - else step←step+1, go to SHOW_ON.
- INPUT: btn == 0 means wait. Otherwise:
  - More than one bit set, or the set bit ≠ mem[step]: go to LOSE.
  - Correct press with step < level−1: step←step+1.
  - Correct press with step == level−1: go to WIN if level == MAX_LEVEL, else APPEND.
- WIN / LOSE: assert the pulse for one cycle, then go to IDLE. level and step are held.
- start outside IDLE is ignored. btn outside INPUT is ignored.
- Sequence memory: MAX_LEVEL×CW, not reset; only indices < level are ever read.
- Illegal state encoding goes to IDLE on the next cycle.

## Timing
- Reset values:
  - state IDLE; level 0; step 0; lfsr LFSR_SEED.
  - show_valid 0; show_color 0; awaiting_input 0; win 0; lose 0; internal tick counters 0.
- Reset mid-game aborts immediately, with no win/lose pulse.
- All outputs are registered.
- Start accepted at edge T: APPEND at T+1, show_valid high from T+2 through T+1+SHOW_TICKS.
- One element occupies SHOW_TICKS+GAP_TICKS cycles. awaiting_input rises GAP_TICKS cycles after the last show_valid.
- A press sampled at edge T moves step, or raises win/lose, at T+1.
- Step following a correct final press: WIN at T+1, or APPEND at T+1 with the next show_valid at T+2.

## Configuration
- GENIUS_TIMEOUT_EN defined:
  - A counter runs in INPUT, cleared on entry to INPUT and on every correct press.
  - Reaching TIMEOUT_TICKS with btn == 0 goes to LOSE.
  - A press on the exact cycle the count expires is evaluated, not timed out.
- GENIUS_TIMEOUT_EN undefined: the counter is removed and INPUT waits indefinitely. TIMEOUT_TICKS is unused.

## Structure
- Shared package genius_pkg:
  - state encoding localparams;
  - LFSR width and tap mask;
  - default LFSR seed.
  It is reused by the display decoders that read level and step.
- One sub-module, genius_lfsr: 16-bit free-running LFSR with seed parameter and synchronous reset.
- Sequence memory and FSM live in genius_core.

## Test plan
- Reset: hold reset 3 cycles mid-SHOW_ON → next cycle all outputs 0, level 0, state IDLE; no win/lose pulse.
- First level (defaults): start at T → show_valid high T+2..T+5, show_color = mem[0] < 4; awaiting_input rises at T+8.
- Correct play, MAX_LEVEL=3: echo each shown colour → level goes 1→2→3; win pulses exactly once; return to IDLE with level=3.
- Wrong press: in INPUT at level 2, step 0, press a colour ≠ mem[0] → lose pulse next cycle, then IDLE with level=2.
- Multi-press and ignored inputs: btn=4'b0011 in INPUT → lose. btn pulses during SHOW_ON and start during INPUT → no state change.
- Timeout (GENIUS_TIMEOUT_EN, TIMEOUT_TICKS=8): no press for 8 cycles in INPUT → lose. A correct press at cycle 7 → step advances and the counter restarts.
